hilo_divider: RTL and testbench
===============================

Name: hilo_divider

Overview:
- Multi-cycle unsigned divide unit with integrated HI/LO register pair for the basic MIPS datapath.
- Sits directly upstream of the result select mux and drives its HiOut/LoOut inputs.
- Starts on funct DIVU, iterates one quotient bit per clock, then commits remainder to HI and quotient to LO.
- mfhi/mflo read HiOut/LoOut combinationally from the held registers.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DIVU_FUNCT, 6'b011011, funct code that starts a division.
- MULTU_FUNCT, 6'b011001, funct code that starts a multiply (only used with the optional feature).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- dataA  input  WIDTH  dividend (rs).
- dataB  input  WIDTH  divisor (rt).
- Signal  input  6  funct code of the current instruction.
- HiOut  output  WIDTH  HI register (remainder after divu).
- LoOut  output  WIDTH  LO register (quotient after divu).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI/LO have just been written.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; HiOut=0, LoOut=0, busy=0, done=0.
  - Internal remainder, quotient and count cleared.
  - Reset wins over every other event, including mid-operation; any partial result is discarded.
- States:
  - IDLE -> RUN when Signal==DIVU_FUNCT.
  - RUN -> COMMIT when count==WIDTH-1 after that edge's iteration.
  - COMMIT -> IDLE unconditionally.
- Start, edge E0 (IDLE with Signal==DIVU_FUNCT):
  - Latch dividend=dataA, divisor=dataB, partial remainder=0, count=0.
  - busy=1 from E0.
  - Any other Signal value in IDLE: no state change; HI/LO hold.
- RUN (restoring algorithm), edges E1..E(WIDTH):
  - Shift {rem,dividend} left by 1.
  - If rem_shifted >= divisor: rem = rem_shifted - divisor and set quotient LSB to 1; else set it to 0.
  - count++.
  - Compare and subtract are WIDTH+1 bits wide so no carry is lost.
- COMMIT, edge E(WIDTH+1):
  - HiOut=remainder, LoOut=quotient; done=1 for exactly that one cycle.
  - busy=0 from this edge. The registered outputs reflect COMMIT state: busy drops and done rises on the same edge.
  - Next edge: done=0, state=IDLE.
- Total latency: HI/LO valid WIDTH+1 edges after the start edge (33 for WIDTH=32).
- Operands are sampled only at E0; changes to dataA/dataB during RUN are ignored.
- Divide by zero: no trap. The algorithm naturally yields LO=all ones and HI=dataA; required as-is.
- Signal==DIVU_FUNCT while busy or in COMMIT: ignored, no restart.
- Start is level-sampled in IDLE. If Signal stays DIVU_FUNCT after COMMIT, a new division starts on the IDLE edge; the controller holds Signal for one cycle only.
- HiOut/LoOut change only at COMMIT or reset; they are stable during RUN, so mfhi/mflo during RUN return the previous result.

Optional Feature:
- Macro: HILO_MULTU_EN.
- Defined:
  - Signal==MULTU_FUNCT in IDLE starts a WIDTH-cycle shift-add unsigned multiply.
  - Same state flow, latency, busy/done timing and ignore-while-busy rules as divide.
  - COMMIT writes HiOut = upper WIDTH bits and LoOut = lower WIDTH bits of the 2*WIDTH product.
- Undefined: MULTU_FUNCT is treated as any other non-start code; no multiply logic is synthesised.

Test Plan:
- Reset low 2 cycles then high, Signal=0 -> HiOut=0, LoOut=0, busy=0, done=0.
- dataA=100, dataB=7, Signal=DIVU 1 cycle -> busy=1 for 33 cycles; done pulses once at E33; LoOut=14, HiOut=2; values held afterwards.
- dataA=0xFFFFFFFF, dataB=1 -> LoOut=0xFFFFFFFF, HiOut=0; then dataA=5, dataB=0 -> LoOut=0xFFFFFFFF, HiOut=5.
- Start 100/7, then at E10 pulse DIVU with dataA=9, dataB=3 and change dataA/dataB -> second start ignored; result still LoOut=14, HiOut=2 at E33.
- Start 100/7 with previous HI/LO = 2/14, assert reset at E15 -> next edge HiOut=0, LoOut=0, busy=0; no done pulse follows.
- With HILO_MULTU_EN: dataA=0x80000000, dataB=4, Signal=MULTU -> HiOut=2, LoOut=0 after 33 edges. Without the macro: same stimulus -> busy stays 0 and HI/LO unchanged.

Source files
------------

// File: rtl/hilo_divider_if.sv
// Operand/funct/result bundle between the datapath controller and the HI/LO divide unit.
// The master drives operands and funct; the slave returns HI/LO plus busy/done status.
interface hilo_divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             busy;
  logic             done;

  // A start is a level on Signal sampled while idle; done pulses one cycle when HI/LO change.
  modport master (output dataA, dataB, Signal, input HiOut, LoOut, busy, done);
  modport slave  (input dataA, dataB, Signal, output HiOut, LoOut, busy, done);
endinterface

// File: rtl/hilo_divider.sv
// Multi-cycle restoring unsigned divider with HI/LO result registers (remainder/quotient).
// Optional shift-add unsigned multiply is enabled by defining HILO_MULTU_EN.
module hilo_divider #(
  parameter int          WIDTH       = 32,
  parameter logic [5:0]  DIVU_FUNCT  = 6'b011011
`ifdef HILO_MULTU_EN
  , parameter logic [5:0] MULTU_FUNCT = 6'b011001
`endif
) (
  input  logic          clk,
  input  logic          reset,
  hilo_divider_if.slave bus,
  output logic [1:0]    o_dbg_state
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_start;
  logic             w_busy;
  logic             w_iter;
  logic             w_commit;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

`ifdef HILO_MULTU_EN
  logic             r_op_mul;
  logic             w_mul_code;
  logic [WIDTH:0]   w_sum;
  assign w_mul_code = (bus.Signal == MULTU_FUNCT);
  assign w_start    = (r_state == S_IDLE) && ((bus.Signal == DIVU_FUNCT) || w_mul_code);
`else
  assign w_start    = (r_state == S_IDLE) && (bus.Signal == DIVU_FUNCT);
`endif

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_RUN;
      S_RUN:    if (r_count == LAST_CNT) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_iter   = (r_state == S_RUN);
    w_commit = (r_state == S_COMMIT);
  end

  // One iteration: compare is WIDTH+1 wide; the subtract result always fits WIDTH bits.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_divisor});
    w_diff    = w_rem_sh[WIDTH-1:0] - r_divisor;
    w_rem_nxt = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
`ifdef HILO_MULTU_EN
    // Multiply reuses the pair as {product_hi, multiplier}, shifting right each step.
    w_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_divisor} : '0);
    if (r_op_mul) begin
      w_rem_nxt = w_sum[WIDTH:1];
      w_quo_nxt = {w_sum[0], r_quo[WIDTH-1:1]};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
`ifdef HILO_MULTU_EN
      r_op_mul  <= 1'b0;
`endif
    end else begin
      r_done <= w_commit;
      if (w_start) begin
        r_rem     <= '0;
        r_quo     <= bus.dataA;
        r_divisor <= bus.dataB;
        r_count   <= '0;
`ifdef HILO_MULTU_EN
        r_op_mul  <= w_mul_code;
`endif
      end else if (w_iter) begin
        r_rem   <= w_rem_nxt;
        r_quo   <= w_quo_nxt;
        r_count <= r_count + 1'b1;
      end
      if (w_commit) begin
        r_hi <= r_rem;
        r_lo <= r_quo;
      end
    end
  end

  assign bus.HiOut   = r_hi;
  assign bus.LoOut   = r_lo;
  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed and randomized bench for hilo_divider against an arithmetic reference model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hilo_divider;
  localparam int         W     = 32;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MULTU = 6'b011001;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   dbg_state;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  hilo_divider_if #(.WIDTH(W)) bus ();

  hilo_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input logic [5:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo);
    logic [2*W-1:0] p;
    if (code == MULTU) begin
      p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      hi = p[2*W-1:W];
      lo = p[W-1:0];
    end else if (b == 0) begin
      hi = a;
      lo = '1;
    end else begin
      hi = a % b;
      lo = a / b;
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] code, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int poke_at, input bit expect_start);
    logic [W-1:0] eh, el;
    int n;
    bit busy_ok, held_ok, seen;
    @(negedge clk);
    bus.dataA = a; bus.dataB = b; bus.Signal = code;
    @(negedge clk);
    bus.Signal = 6'd0; bus.dataA = $urandom; bus.dataB = $urandom;
    if (!expect_start) begin
      check({tag, "_busy_idle"}, W'(bus.busy), '0);
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (bus.busy || bus.done) seen = 1'b1;
      end
      check({tag, "_no_activity"}, W'(seen), '0);
      check({tag, "_hi_hold"}, bus.HiOut, model_hi);
      check({tag, "_lo_hold"}, bus.LoOut, model_lo);
      return;
    end
    check({tag, "_busy_e0"}, W'(bus.busy), W'(1));
    model_op(code, a, b, eh, el);
    n = 0; busy_ok = 1'b1; held_ok = 1'b1;
    while (!bus.done && n < 60) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.HiOut !== model_hi || bus.LoOut !== model_lo) held_ok = 1'b0;
      if (n == poke_at) begin
        bus.Signal = DIVU; bus.dataA = 32'd9; bus.dataB = 32'd3;
      end else begin
        bus.Signal = 6'd0;
      end
      @(negedge clk);
      n++;
    end
    bus.Signal = 6'd0;
    check({tag, "_latency"}, W'(n), W'(33));
    check({tag, "_busy_run"}, W'(busy_ok), W'(1));
    check({tag, "_held_run"}, W'(held_ok), W'(1));
    check({tag, "_done"}, W'(bus.done), W'(1));
    check({tag, "_busy_commit"}, W'(bus.busy), '0);
    check({tag, "_hi"}, bus.HiOut, eh);
    check({tag, "_lo"}, bus.LoOut, el);
    model_hi = eh;
    model_lo = el;
    @(negedge clk);
    check({tag, "_done_drop"}, W'(bus.done), '0);
    check({tag, "_hi_after"}, bus.HiOut, model_hi);
    check({tag, "_lo_after"}, bus.LoOut, model_lo);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit seen;
    reset = 1'b0;
    bus.Signal = 6'd0; bus.dataA = '0; bus.dataB = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_hi", bus.HiOut, '0);
    check("rst_lo", bus.LoOut, '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);

    run_op("d100_7", DIVU, 32'd100, 32'd7, -1, 1'b1);
    run_op("dmax_1", DIVU, 32'hFFFF_FFFF, 32'd1, -1, 1'b1);
    run_op("d5_0", DIVU, 32'd5, 32'd0, -1, 1'b1);
    run_op("d100_7_poke", DIVU, 32'd100, 32'd7, 10, 1'b1);
    run_op("nop_code", 6'b100000, 32'd1, 32'd2, -1, 1'b0);

    // Reset lands on edge E15 of a running division.
    @(negedge clk);
    bus.dataA = 32'd100; bus.dataB = 32'd7; bus.Signal = DIVU;
    @(negedge clk);
    bus.Signal = 6'd0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_hi = '0;
    model_lo = '0;
    check("midrst_hi", bus.HiOut, '0);
    check("midrst_lo", bus.LoOut, '0);
    check("midrst_busy", W'(bus.busy), '0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("midrst_no_done", W'(seen), '0);

`ifdef HILO_MULTU_EN
    run_op("mul_hi", MULTU, 32'h8000_0000, 32'd4, -1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      run_op("mul_rand", MULTU, ra, rb, -1, 1'b1);
    end
`else
    run_op("mul_off", MULTU, 32'h8000_0000, 32'd4, -1, 1'b0);
`endif

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 1) ? 32'($urandom) : 32'($urandom_range(0, 255));
      run_op("div_rand", DIVU, ra, rb, -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
